output_fm_store: RTL and testbench

- Drains one finished output-feature-map tile from 4 physical result banks into the outbound FIFO toward external memory.
- It is the read/transmit counterpart of the input-tile loader:
  - the loader pops a FIFO and writes one slice per bank;
  - this block reads the banks slice by slice and pushes the words into a FIFO.
- Sits between the output_fm bank array and the output DMA FIFO.

---
 rtl/out_fm_pkg.sv | 27 ++
 rtl/out_fm_skid_buf.sv | 59 +++++
 rtl/output_fm_store.sv | 179 +++++++++++++++++
 tb/tb_output_fm_store.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/out_fm_pkg.sv
// Shared types and geometry helpers for the output feature-map store path.
// Geometry is expressed as functions so each instance derives it from its own tile parameters.
package out_fm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } fm_state_e;

    typedef logic [1:0] bank_idx_t;

    localparam int NUM_BANKS = 4;

    function automatic int slice_size(input int tr, input int tc);
        return tr * tc;
    endfunction

    function automatic int tile_size(input int tm, input int tr, input int tc);
        return tm * tr * tc;
    endfunction

    function automatic int bank_depth(input int tm, input int tr, input int tc);
        return (tm / NUM_BANKS) * tr * tc;
    endfunction

endpackage

// File: rtl/out_fm_skid_buf.sv
// Two-entry skid buffer between the bank read pipeline and the outbound FIFO.
// The occupancy count is exported so the reader can budget its outstanding reads.
module out_fm_skid_buf #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          out_pop,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [1:0]    count
);

    logic [DW-1:0] ent0_r;
    logic [DW-1:0] ent1_r;
    logic [1:0]    cnt_r;

    // Entry storage; ent0_r is always the head, a simultaneous capture and pop keeps occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_r <= {DW{1'b0}};
            ent1_r <= {DW{1'b0}};
            cnt_r  <= 2'd0;
        end else begin
            case ({in_valid, out_pop})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        ent0_r <= in_data;
                    end else begin
                        ent1_r <= in_data;
                    end
                    cnt_r <= cnt_r + 2'd1;
                end
                2'b01: begin
                    ent0_r <= ent1_r;
                    cnt_r  <= cnt_r - 2'd1;
                end
                2'b11: begin
                    if (cnt_r == 2'd1) begin
                        ent0_r <= in_data;
                    end else begin
                        ent0_r <= ent1_r;
                        ent1_r <= in_data;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign out_valid = (cnt_r != 2'd0);
    assign out_data  = ent0_r;
    assign count     = cnt_r;

endmodule

// File: rtl/output_fm_store.sv
// Streams one finished output tile from four result banks into the outbound FIFO,
// channel-major and offset-minor, with a two-credit read pipeline feeding a skid buffer.
module output_fm_store
    import out_fm_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int Tm = 16,
    parameter int Tr = 64,
    parameter int Tc = 16,
    parameter int X  = 4
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] rd_addr0,
    output logic [AW-1:0] rd_addr1,
    output logic [AW-1:0] rd_addr2,
    output logic [AW-1:0] rd_addr3,
    input  logic [DW-1:0] rd_data0,
    input  logic [DW-1:0] rd_data1,
    input  logic [DW-1:0] rd_data2,
    input  logic [DW-1:0] rd_data3,
    output logic [DW-1:0] out_fm_fifo_data,
    output logic          out_fm_fifo_push,
    input  logic          out_fm_fifo_full,
    input  logic          out_fm_store_start,
    output logic          out_fm_store_done,
    output logic          out_fm_store_busy
);

    localparam int SLICE = slice_size(Tr, Tc);
    localparam int TILE  = tile_size(Tm, Tr, Tc);
    localparam logic [AW-1:0]   ONE_A      = AW'(1);
    localparam logic [AW-1:0]   SLICE_A    = AW'(SLICE);
    localparam logic [AW-1:0]   OFF_LAST   = AW'(SLICE - 1);
    localparam logic [AW-1:0]   CHAN_LAST  = AW'(Tm - 1);
    localparam logic [AW+1:0]   PUSH_LAST  = (AW+2)'(TILE - 1);
    localparam logic [AW+1:0]   ONE_P      = (AW+2)'(1);

    fm_state_e     state_r, next_s;
    logic [AW-1:0] offset_r, chan_r, base_r;
    logic [AW+1:0] push_cnt_r;
    logic [AW-1:0] addr_r [0:3];
    bank_idx_t     sel_r, bank_s;
    logic          inflight_r, done_r, busy_r;
    logic [1:0]    count_s;
    logic [2:0]    credit_s;
    logic          head_valid_s, pop_s, issue_s, last_rd_s, last_push_s, start_acc_s;
    logic [DW-1:0] head_s, cap_data_s;

    // Credit, issue and completion decisions for the current cycle.
    always_comb begin
        bank_s      = chan_r[1:0];
        pop_s       = head_valid_s && !out_fm_fifo_full;
        credit_s    = {1'b0, count_s} - {2'b00, pop_s} + {2'b00, inflight_r};
        issue_s     = (state_r == STREAM) && (credit_s < 3'd2);
        last_rd_s   = (chan_r == CHAN_LAST) && (offset_r == OFF_LAST);
        last_push_s = (state_r == DRAIN) && pop_s && (push_cnt_r == PUSH_LAST);
        start_acc_s = (state_r == IDLE) && out_fm_store_start && !done_r;
    end

    // Next-state logic; start is refused during the done cycle so the block re-arms one cycle later.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_acc_s) next_s = STREAM;
                else             next_s = IDLE;
            end
            STREAM: begin
                if (issue_s && last_rd_s) next_s = DRAIN;
                else                      next_s = STREAM;
            end
            DRAIN: begin
                if (last_push_s) next_s = IDLE;
                else             next_s = DRAIN;
            end
            default: next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= IDLE;
        else      state_r <= next_s;
    end

    // Read-side walk over offset, channel and bank address base, plus the tile push counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            offset_r   <= {AW{1'b0}};
            chan_r     <= {AW{1'b0}};
            base_r     <= {AW{1'b0}};
            push_cnt_r <= {(AW+2){1'b0}};
        end else if (start_acc_s) begin
            offset_r   <= {AW{1'b0}};
            chan_r     <= {AW{1'b0}};
            base_r     <= {AW{1'b0}};
            push_cnt_r <= {(AW+2){1'b0}};
        end else begin
            if (issue_s) begin
                if (offset_r == OFF_LAST) begin
                    offset_r <= {AW{1'b0}};
                    if (chan_r == CHAN_LAST) begin
                        chan_r <= {AW{1'b0}};
                        base_r <= {AW{1'b0}};
                    end else begin
                        chan_r <= chan_r + ONE_A;
                        if (chan_r[1:0] == 2'(X - 1)) base_r <= base_r + SLICE_A;
                    end
                end else begin
                    offset_r <= offset_r + ONE_A;
                end
            end
            if (pop_s) push_cnt_r <= push_cnt_r + ONE_P;
        end
    end

    // Registered bank addresses; only the selected bank sees a nonzero address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 4; b++) addr_r[b] <= {AW{1'b0}};
            sel_r      <= 2'd0;
            inflight_r <= 1'b0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                addr_r[b] <= (issue_s && (bank_s == 2'(b))) ? (base_r + offset_r) : {AW{1'b0}};
            end
            sel_r      <= issue_s ? bank_s : sel_r;
            inflight_r <= issue_s;
        end
    end

    // Return-data mux, steered by the select that travelled with the address.
    always_comb begin
        cap_data_s = rd_data0;
        case (sel_r)
            2'd0:    cap_data_s = rd_data0;
            2'd1:    cap_data_s = rd_data1;
            2'd2:    cap_data_s = rd_data2;
            2'd3:    cap_data_s = rd_data3;
            default: cap_data_s = rd_data0;
        endcase
    end

    // Status flags: busy spans start accept to the done cycle, done is a single pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            done_r <= last_push_s;
            if (start_acc_s)      busy_r <= 1'b1;
            else if (last_push_s) busy_r <= 1'b0;
            else                  busy_r <= busy_r;
        end
    end

    out_fm_skid_buf #(.DW(DW)) u_skid (
        .clk       (clk),
        .rst_n     (rst),
        .in_valid  (inflight_r),
        .in_data   (cap_data_s),
        .out_pop   (pop_s),
        .out_valid (head_valid_s),
        .out_data  (head_s),
        .count     (count_s)
    );

    assign rd_addr0          = addr_r[0];
    assign rd_addr1          = addr_r[1];
    assign rd_addr2          = addr_r[2];
    assign rd_addr3          = addr_r[3];
    assign out_fm_fifo_data  = head_s;
    assign out_fm_fifo_push  = pop_s;
    assign out_fm_store_done = done_r;
    assign out_fm_store_busy = busy_r;

endmodule

// File: tb/tb_output_fm_store.sv
// Directed bench for output_fm_store with a small tile (8 channels, 2x2 slices, 32 words).
// Banks are modelled as combinational reads of a preloaded pattern 16*channel+offset.
module tb_output_fm_store;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int TM   = 8;
    localparam int TR   = 2;
    localparam int TC   = 2;
    localparam int TILE = 32;

    logic          clk = 1'b0;
    logic          rst, start, full;
    logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
    logic [DW-1:0] rd_data0, rd_data1, rd_data2, rd_data3;
    logic [DW-1:0] fifo_data;
    logic          push, done, busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] pushed [$];
    int done_cnt, busy_cnt, cyc, first_busy_cyc, first_push_cyc, last_push_cyc, done_cyc, multi_sel;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] bank_val(input int b, input logic [AW-1:0] a);
        int c;
        c = (int'(a) / 4) * 4 + b;
        return DW'(16 * c + int'(a) % 4);
    endfunction

    function automatic logic [DW-1:0] exp_word(input int k);
        return DW'(16 * (k / 4) + k % 4);
    endfunction

    function automatic logic [63:0] exp_addr(input int k);
        logic [63:0] v;
        int c;
        c = k / 4;
        v = 64'd0;
        v[(c % 4) * 16 +: 16] = 16'((c / 4) * 4 + k % 4);
        return v;
    endfunction

    assign rd_data0 = bank_val(0, rd_addr0);
    assign rd_data1 = bank_val(1, rd_addr1);
    assign rd_data2 = bank_val(2, rd_addr2);
    assign rd_data3 = bank_val(3, rd_addr3);

    output_fm_store #(.AW(AW), .DW(DW), .Tm(TM), .Tr(TR), .Tc(TC), .X(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .rd_addr0           (rd_addr0),
        .rd_addr1           (rd_addr1),
        .rd_addr2           (rd_addr2),
        .rd_addr3           (rd_addr3),
        .rd_data0           (rd_data0),
        .rd_data1           (rd_data1),
        .rd_data2           (rd_data2),
        .rd_data3           (rd_data3),
        .out_fm_fifo_data   (fifo_data),
        .out_fm_fifo_push   (push),
        .out_fm_fifo_full   (full),
        .out_fm_store_start (start),
        .out_fm_store_done  (done),
        .out_fm_store_busy  (busy)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        pushed.delete();
        done_cnt = 0; busy_cnt = 0; multi_sel = 0;
        first_busy_cyc = 0; first_push_cyc = 0; last_push_cyc = 0; done_cyc = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_tile(input string tag, input int base);
        for (int i = 0; i < TILE; i++) begin
            if (base + i < pushed.size())
                check_val($sformatf("%s_w%0d", tag, i), 64'(pushed[base + i]), 64'(exp_word(i)));
        end
    endtask

    // Output monitor, sampled on the falling edge.
    initial begin
        cyc = 0;
        clear_mon();
        forever begin
            @(negedge clk);
            cyc++;
            if (busy) begin
                if (busy_cnt == 0) first_busy_cyc = cyc;
                busy_cnt++;
            end
            if (push) begin
                if (pushed.size() == 0) first_push_cyc = cyc;
                last_push_cyc = cyc;
                pushed.push_back(fifo_data);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (int'(rd_addr0 != 0) + int'(rd_addr1 != 0) + int'(rd_addr2 != 0) + int'(rd_addr3 != 0) > 1)
                multi_sel++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad, seen1, sz;
        rst = 1'b0; start = 1'b0; full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_addr", {rd_addr3, rd_addr2, rd_addr1, rd_addr0}, 64'd0);
        check_val("rst_ctl", 64'({push, done, busy}), 64'd0);
        check_val("rst_data", 64'(fifo_data), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Unthrottled tile with per-cycle address check.
        clear_mon();
        pulse_start();
        for (int k = 0; k < TILE; k++) begin
            @(posedge clk); #1;
            check_val($sformatf("addr_w%0d", k), {rd_addr3, rd_addr2, rd_addr1, rd_addr0}, exp_addr(k));
        end
        repeat (10) @(posedge clk);
        #1;
        check_val("t1_count", 64'(pushed.size()), 64'(TILE));
        check_tile("t1", 0);
        check_val("t1_busy_cycles", 64'(busy_cnt), 64'd34);
        check_val("t1_done_cnt", 64'(done_cnt), 64'd1);
        check_val("t1_first_push_lat", 64'(first_push_cyc - first_busy_cyc), 64'd2);
        check_val("t1_done_lat", 64'(done_cyc - last_push_cyc), 64'd1);
        check_val("t1_push_span", 64'(last_push_cyc - first_push_cyc), 64'd31);
        check_val("t1_one_sel", 64'(multi_sel), 64'd0);

        // Random backpressure.
        clear_mon();
        pulse_start();
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            full = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        full = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("t3_count", 64'(pushed.size()), 64'(TILE));
        check_tile("t3", 0);
        check_val("t3_done_cnt", 64'(done_cnt), 64'd1);
        check_val("t3_one_sel", 64'(multi_sel), 64'd0);

        // FIFO full from start for 20 cycles.
        full = 1'b1;
        clear_mon();
        pulse_start();
        bad = 0; seen1 = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (rd_addr1 != 0 || rd_addr2 != 0 || rd_addr3 != 0 || rd_addr0 > 1) bad++;
            if (rd_addr0 == 1) seen1++;
        end
        check_val("t4_no_extra_reads", 64'(bad), 64'd0);
        check_val("t4_second_read", 64'(seen1), 64'd1);
        check_val("t4_no_push", 64'(pushed.size()), 64'd0);
        check_val("t4_busy", 64'(busy), 64'd1);
        full = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_val("t4_count", 64'(pushed.size()), 64'(TILE));
        check_tile("t4", 0);
        check_val("t4_no_gaps", 64'(last_push_cyc - first_push_cyc), 64'd31);
        check_val("t4_done_cnt", 64'(done_cnt), 64'd1);

        // Start mid-tile and during done is ignored; start one cycle after done runs again.
        clear_mon();
        pulse_start();
        repeat (10) @(posedge clk);
        #1;
        pulse_start();
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("t5_done_seen", 64'(done), 64'd1);
        start = 1'b1;
        @(posedge clk); #1;
        check_val("t5_start_in_done_ignored", 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check_val("t5_restart", 64'(busy), 64'd1);
        repeat (45) @(posedge clk);
        #1;
        check_val("t5_count", 64'(pushed.size()), 64'(2 * TILE));
        check_tile("t5a", 0);
        check_tile("t5b", TILE);
        check_val("t5_done_cnt", 64'(done_cnt), 64'd2);

        // Reset partway through a tile.
        clear_mon();
        pulse_start();
        n = 0;
        while (pushed.size() < 10 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("t6_reached_w10", 64'(pushed.size() >= 10), 64'd1);
        #2 rst = 1'b0;
        #1;
        check_val("t6_rst_addr", {rd_addr3, rd_addr2, rd_addr1, rd_addr0}, 64'd0);
        check_val("t6_rst_ctl", 64'({push, done, busy}), 64'd0);
        check_val("t6_rst_data", 64'(fifo_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        sz = pushed.size();
        repeat (40) @(posedge clk);
        #1;
        check_val("t6_no_more_push", 64'(pushed.size()), 64'(sz));
        check_val("t6_no_done", 64'(done_cnt), 64'd0);
        clear_mon();
        pulse_start();
        repeat (45) @(posedge clk);
        #1;
        check_val("t6_count", 64'(pushed.size()), 64'(TILE));
        check_tile("t6", 0);
        check_val("t6_done_cnt", 64'(done_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
